serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder: accepts two operands and a carry-in over a valid/ready handshake.
- Feeds one bit pair per cycle, LSB first, into a single fulladder instance; a carry flop closes the loop between bits.
- Shifts sum bits into a result register and presents sum, carry-out and signed overflow on an output valid/ready handshake.
- Low-area counterpart to the 32-bit carry-look-ahead adder; shares its operand/result widths so either can sit behind the same datapath wrapper.

Parameters:
- WIDTH, 32, operand and sum width in bits (legal range 2..64).
- CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- Cin  input  1  carry-in
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- Sum  output  WIDTH  a+b+Cin, low WIDTH bits
- Cout  output  1  carry out of MSB
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, active-high, immediate):
  - state=IDLE, counter=0, carry flop=0, shift registers=0.
  - in_ready=1, out_valid=0, Sum=0, Cout=0, Ovf=0.
- States: IDLE, RUN, DONE. Encoding comes from the shared package.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, capture a and b into shift registers, load the carry flop with Cin, clear the counter, go to RUN.
  - in_valid=0 holds IDLE.
- RUN:
  - in_ready=0.
  - Each cycle: fulladder inputs are a_sh[0], b_sh[0] and the carry flop.
  - Its sum shifts into the MSB of sum_sh (sum_sh shifts right). Its Cout loads the carry flop. a_sh and b_sh shift right. The counter increments.
  - When counter==WIDTH-1, capture the carry flop (carry into MSB) into ovf_cin, then on that cycle's edge go to DONE.
  - Exactly WIDTH cycles are spent in RUN.
- DONE:
  - out_valid=1.
  - Sum=sum_sh; Cout=carry flop; Ovf=ovf_cin ^ carry flop.
  - All of these are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - in_ready=0 in DONE, so there is no overlap.
- Latency: handshake edge at cycle 0; out_valid rises at cycle WIDTH+1. Minimum initiation interval is WIDTH+2 cycles.
- Sum/Cout/Ovf outside DONE: hold their last values; they are registered, never combinational from the inputs.
- Arithmetic is modulo 2^WIDTH. Cout is the true unsigned carry.
- Boundary conditions:
  - in_valid asserted during RUN or DONE is ignored (in_ready=0); a and b may change freely after capture.
  - out_ready asserted before DONE has no effect.
  - out_ready high on the cycle DONE is entered: result is presented for exactly one cycle, then IDLE.
  - rst asserted mid-RUN or in DONE aborts the operation; no partial result becomes visible and out_valid=0 immediately.
  - Counter never wraps: it is cleared on accept and saturates at WIDTH-1.

Decomposition:
- Package serial_adder_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - default WIDTH constant
- Sub-module: the existing fulladder, instantiated once for the per-bit datapath. All sequencing stays in serial_adder_ctrl.

Test Plan:
- Basic add: a=0x0000_0005, b=0x0000_0003, Cin=0 -> out_valid at cycle 33 after accept; Sum=0x0000_0008, Cout=0, Ovf=0.
- Unsigned wrap: a=0xFFFF_FFFF, b=0x0000_0001, Cin=0 -> Sum=0x0000_0000, Cout=1, Ovf=0.
- Signed overflow with carry-in: a=0x7FFF_FFFF, b=0x0000_0000, Cin=1 -> Sum=0x8000_0000, Cout=0, Ovf=1.
- Backpressure:
  - out_ready=0 for 10 cycles after out_valid -> Sum/Cout/Ovf stable and in_ready=0 throughout.
  - in_valid pulsed mid-RUN with different operands -> ignored; result matches the first operands.
  - out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: rst pulsed at RUN cycle 12 -> out_valid=0, in_ready=1 immediately.
  - New accept a=0x1234_5678, b=0x1111_1111, Cin=0 -> Sum=0x2345_6789.
- Randomised back-to-back: 1000 operations with random a/b/Cin and random out_ready -> each result matches the reference model a+b+Cin; no accept is lost or duplicated.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default operand width.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// Single-bit full adder used as the per-bit datapath of the serial adder.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one bit pair per cycle, LSB first, through one full adder,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             fa_sum, fa_cout;

   fulladder u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_comb begin
      // NOTE: every next-state signal gets a hold default first, so no path infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = Cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            if (cnt_q == CNT_LAST) begin
               // Result registers load only here, so Sum/Cout/Ovf never show a partial sum.
               // carry_q is the carry into the MSB on this last bit.
               state_d = ST_DONE;
               sum_d   = sum_sh_d;
               cout_d  = fa_cout;
               ovf_d   = carry_q ^ fa_cout;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign Sum       = sum_q;
   assign Cout      = cout_q;
   assign Ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: scoreboard of reference sums, directed
// scenarios followed by randomised back-to-back traffic with random backpressure.
module tb_serial_adder_ctrl;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         Cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Sum;
   logic         Cout;
   logic         Ovf;

   res_t sb_q[$];
   int   n_checks  = 0;
   int   n_errors  = 0;
   int   n_acc     = 0;
   int   n_res     = 0;
   int   n_aborted = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .Cin       (Cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .Cout      (Cout),
      .Ovf       (Ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready)   n_acc++;
         if (out_valid && out_ready) n_res++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] full;
      res_t       r;
      full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
      return r;
   endfunction

   // Called at a negedge in IDLE; returns at the first negedge after the accept edge.
   task automatic do_accept(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
      end
      a        = ta;
      b        = tb_v;
      Cin      = tc;
      in_valid = 1'b1;
      sb_q.push_back(model(ta, tb_v, tc));
      @(negedge clk);
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      Cin      = 1'($urandom_range(0, 1));
   endtask

   // Waits (bounded) for out_valid; lat counts negedges since the accept edge.
   task automatic wait_valid(input int start, input bit rand_ready);
      int lat;
      lat = start;
      while (!out_valid && lat < W + 20) begin
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (!out_valid || lat != W + 1) begin
         n_errors++;
         $display("FAIL latency: out_valid=%b after %0d cycles, required 1 after %0d", out_valid, lat, W + 1);
      end
   endtask

   // Compares the presented result every cycle of DONE, then completes the handshake.
   task automatic collect(input bit rand_ready, input int stall);
      res_t exp_r;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_errors++;
         $display("FAIL scoreboard_empty: result with size 0, required an expected entry");
         return;
      end
      exp_r = sb_q.pop_front();
      for (int i = 0; i < 200; i++) begin
         n_checks++;
         if ({Sum, Cout, Ovf, in_ready, out_valid} !== {exp_r.sum, exp_r.cout, exp_r.ovf, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL result: Sum=%h Cout=%b Ovf=%b in_ready=%b out_valid=%b required Sum=%h Cout=%b Ovf=%b in_ready=0 out_valid=1",
                     Sum, Cout, Ovf, in_ready, out_valid, exp_r.sum, exp_r.cout, exp_r.ovf);
         end
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'(i >= stall);
         @(negedge clk);
         if (out_ready) break;
      end
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL return_idle: out_valid=%b in_ready=%b required 0 and 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({in_ready, out_valid, Sum, Cout, Ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b Sum=%h Cout=%b Ovf=%b required 1 0 0 0 0",
                  in_ready, out_valid, Sum, Cout, Ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [W-1:0] va [3];
      logic [W-1:0] vb [3];
      logic         vc [3];
      va[0] = 32'h0000_0005; vb[0] = 32'h0000_0003; vc[0] = 1'b0;
      va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0001; vc[1] = 1'b0;
      va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0000; vc[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         do_accept(va[k], vb[k], vc[k]);
         wait_valid(1, 1'b0);
         collect(1'b0, 0);
      end
   endtask

   task automatic test_backpressure();
      int acc_before;
      do_accept(32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
      acc_before = n_acc;
      in_valid   = 1'b1;
      a          = 32'h1111_1111;
      b          = 32'h2222_2222;
      Cin        = 1'b0;
      out_ready  = 1'b1;
      repeat (3) @(negedge clk);
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      n_checks++;
      if (n_acc !== acc_before) begin
         n_errors++;
         $display("FAIL ignore_in_valid: accepts=%0d required %0d", n_acc, acc_before);
      end
      wait_valid(4, 1'b0);
      collect(1'b0, 10);
   endtask

   task automatic test_reset_mid_run();
      res_t dropped;
      do_accept(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
      repeat (11) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, in_ready, Sum, Cout, Ovf} !== {1'b0, 1'b1, {W{1'b0}}, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_mid_run: out_valid=%b in_ready=%b Sum=%h Cout=%b Ovf=%b required 0 1 0 0 0",
                  out_valid, in_ready, Sum, Cout, Ovf);
      end
      dropped = sb_q.pop_back();
      n_aborted++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_accept(32'h1234_5678, 32'h1111_1111, 1'b0);
      wait_valid(1, 1'b0);
      n_checks++;
      if (Sum !== 32'h2345_6789) begin
         n_errors++;
         $display("FAIL post_reset_sum: Sum=%h required 23456789", Sum);
      end
      collect(1'b0, 2);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 1000; k++) begin
         do_accept($urandom, $urandom, 1'($urandom_range(0, 1)));
         wait_valid(1, 1'b1);
         collect(1'b1, 0);
      end
      n_checks++;
      if (sb_q.size() != 0 || n_acc != n_res + n_aborted) begin
         n_errors++;
         $display("FAIL accept_count: accepts=%0d results=%0d aborted=%0d pending=%0d required accepts=results+aborted, pending 0",
                  n_acc, n_res, n_aborted, sb_q.size());
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      Cin       = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
